scrypt_slot_sched: RTL and testbench

- Scheduler that time-multiplexes the 16-cycle pipelined salsa datapath between SLOTS independent scrypt ROMix jobs, one slot per pipeline stage.
- Each cycle it visits one slot: it retires or advances that slot's returning result and chooses the next input for the pipeline.
- It drives the scratchpad address and write enable for the write phase (V[i]=X) and the read phase (X=H(X^V[j])).
- It sits between the job feeder and the salsa datapath and scratchpad.

---
 rtl/scrypt_slot_sched.sv | 177 +++++++++++++++++
 tb/tb_scrypt_slot_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/scrypt_slot_sched.sv
// Slot scheduler for the 16-stage salsa pipeline running interleaved ROMix jobs.
// Each cycle one slot is visited. The visit either retires or advances the
// result returning from the pipeline, and it selects the next datapath input.
// It also drives the scratchpad address and write strobe for that slot.
// Per-slot state:
//   phase  | meaning
//   IDLE   | slot free; takes a job when the feeder offers one
//   WRITE  | filling V[0..N-1] with successive hashes of X
//   READ   | N data-dependent passes X = H(X ^ V[Xaddr])
module scrypt_slot_sched #(
  parameter int SLOTS  = 16,
  parameter int SLOT_W = 4,
  parameter int N      = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_flush,
  input  logic                     i_job_valid,
  output logic                     o_job_ready,
  input  logic [ADDR_W-1:0]        i_xaddr,
  output logic [SLOT_W-1:0]        o_slot,
  output logic [1:0]               o_issue_sel,
  output logic                     o_ram_we,
  output logic [SLOT_W+ADDR_W-1:0] o_ram_addr,
  output logic                     o_result_valid,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WRITE = 2'd1,
    PH_READ  = 2'd2
  } phase_t;

  localparam logic [1:0] SEL_BUBBLE = 2'd0;
  localparam logic [1:0] SEL_LOAD   = 2'd1;
  localparam logic [1:0] SEL_FB     = 2'd2;
  localparam logic [1:0] SEL_FB_XOR = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N - 1);
  localparam logic [SLOT_W-1:0] LAST_PTR = SLOT_W'(SLOTS - 1);

  logic [SLOT_W-1:0] r_ptr;
  logic              r_busy;
  phase_t            r_phase [SLOTS];
  logic [ADDR_W-1:0] r_count [SLOTS];

  phase_t            w_phase_cur;
  logic [ADDR_W-1:0] w_count_cur;
  logic              w_last;
  phase_t            w_phase_nxt;
  logic [ADDR_W-1:0] w_count_nxt;
  logic              w_busy_nxt;

  // The latency equals SLOTS, so the slot returning a result this cycle is also
  // the slot being issued. Only that slot's entry is read.
  assign w_phase_cur = r_phase[r_ptr];
  assign w_count_cur = r_count[r_ptr];
  assign w_last      = (w_count_cur == LAST_CNT);

  // State register: slot pointer, per-slot phase/count arrays, registered busy
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr  <= '0;
      r_busy <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        r_phase[i] <= PH_IDLE;
        r_count[i] <= '0;
      end
    end else begin
      r_ptr  <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
      r_busy <= w_busy_nxt;
      if (i_flush) begin
        for (int i = 0; i < SLOTS; i++) begin
          r_phase[i] <= PH_IDLE;
          r_count[i] <= '0;
        end
      end else begin
        r_phase[r_ptr] <= w_phase_nxt;
        r_count[r_ptr] <= w_count_nxt;
      end
    end
  end

  // Next-state logic for the visited slot
  always_comb begin
    w_phase_nxt = w_phase_cur;
    w_count_nxt = w_count_cur;
    case (w_phase_cur)
      PH_IDLE: begin
        if (i_job_valid) begin
          w_phase_nxt = PH_WRITE;
          w_count_nxt = '0;
        end
      end
      PH_WRITE: begin
        if (w_last) begin
          w_phase_nxt = PH_READ;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = w_count_cur + 1'b1;
        end
      end
      PH_READ: begin
        if (w_last) begin
          w_phase_nxt = PH_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = w_count_cur + 1'b1;
        end
      end
      default: begin
        w_phase_nxt = PH_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Busy after the edge: some slot left non-IDLE, with flush clearing all of them
  always_comb begin
    w_busy_nxt = 1'b0;
    if (!i_flush) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (SLOT_W'(i) == r_ptr) begin
          if (w_phase_nxt != PH_IDLE) w_busy_nxt = 1'b1;
        end else if (r_phase[i] != PH_IDLE) begin
          w_busy_nxt = 1'b1;
        end
      end
    end
  end

  // Output decode for the visited slot. Reset and flush force every strobe low.
  always_comb begin
    o_job_ready    = 1'b0;
    o_issue_sel    = SEL_BUBBLE;
    o_ram_we       = 1'b0;
    o_ram_addr     = '0;
    o_result_valid = 1'b0;
    if (i_reset_n && !i_flush) begin
      case (w_phase_cur)
        PH_IDLE: begin
          o_job_ready = i_job_valid;
          if (i_job_valid) begin
            o_issue_sel = SEL_LOAD;
            o_ram_we    = 1'b1;
            o_ram_addr  = {r_ptr, {ADDR_W{1'b0}}};
          end
        end
        PH_WRITE: begin
          if (w_last) begin
            o_issue_sel = SEL_FB_XOR;
            o_ram_addr  = {r_ptr, i_xaddr};
          end else begin
            o_issue_sel = SEL_FB;
            o_ram_we    = 1'b1;
            o_ram_addr  = {r_ptr, w_count_cur + 1'b1};
          end
        end
        PH_READ: begin
          if (w_last) begin
            o_result_valid = 1'b1;
          end else begin
            o_issue_sel = SEL_FB_XOR;
            o_ram_addr  = {r_ptr, i_xaddr};
          end
        end
        default: ;
      endcase
    end
  end

  assign o_slot = r_ptr;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_scrypt_slot_sched.sv
// Scoreboard bench for scrypt_slot_sched with a small N (4) and 16 slots.
// The driver computes each cycle's expected outputs from the job timeline and
// pushes them. The timeline is: accept time plus the slot's visit count since
// acceptance. A monitor on the falling edge pops each entry and compares it.
module tb_scrypt_slot_sched;

  localparam int SLOTS  = 16;
  localparam int SLOT_W = 4;
  localparam int N      = 4;
  localparam int ADDR_W = 2;
  localparam int AW     = SLOT_W + ADDR_W;
  localparam int EW     = 1 + SLOT_W + 2 + 1 + AW + 1 + 1;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_flush;
  logic              i_job_valid;
  logic              o_job_ready;
  logic [ADDR_W-1:0] i_xaddr;
  logic [SLOT_W-1:0] o_slot;
  logic [1:0]        o_issue_sel;
  logic              o_ram_we;
  logic [AW-1:0]     o_ram_addr;
  logic              o_result_valid;
  logic              o_busy;

  scrypt_slot_sched #(.SLOTS(SLOTS), .SLOT_W(SLOT_W), .N(N), .ADDR_W(ADDR_W)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_flush        (i_flush),
    .i_job_valid    (i_job_valid),
    .o_job_ready    (o_job_ready),
    .i_xaddr        (i_xaddr),
    .o_slot         (o_slot),
    .o_issue_sel    (o_issue_sel),
    .o_ram_we       (o_ram_we),
    .o_ram_addr     (o_ram_addr),
    .o_result_valid (o_result_valid),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Expected vector layout: {ready, slot, sel, we, addr, result_valid, busy}
  logic [EW-1:0] exp_q [$];
  int            cyc_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  // Reference model: which slots hold a job and the cycle it was accepted
  bit m_active [SLOTS];
  int m_start  [SLOTS];
  int m_cyc;

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge i_clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    int            c;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cyc_q.pop_front();
      a = {o_job_ready, o_slot, o_issue_sel, o_ram_we, o_ram_addr, o_result_valid, o_busy};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got ready=%b slot=%0d sel=%0d we=%b addr=%h rv=%b busy=%b want ready=%b slot=%0d sel=%0d we=%b addr=%h rv=%b busy=%b",
                 c, a[EW-1], a[EW-2 -: SLOT_W], a[AW+3 -: 2], a[AW+2], a[AW+1 -: AW], a[1], a[0],
                 e[EW-1], e[EW-2 -: SLOT_W], e[AW+3 -: 2], e[AW+2], e[AW+1 -: AW], e[1], e[0]);
      end
    end
  end

  // One cycle: apply inputs just after the edge, predict outputs, then advance
  task automatic step(input bit rst_n, input bit fl, input bit jv);
    logic [ADDR_W-1:0] xa;
    bit                e_ready, e_we, e_rv, e_busy;
    logic [1:0]        e_sel;
    logic [AW-1:0]     e_addr;
    int                s, k;
    xa          = ADDR_W'($urandom_range(0, N - 1));
    i_reset_n   = rst_n;
    i_flush     = fl;
    i_job_valid = jv;
    i_xaddr     = xa;
    e_ready = 0; e_we = 0; e_rv = 0; e_busy = 0; e_sel = 2'd0; e_addr = '0;
    s = m_cyc % SLOTS;
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) m_active[i] = 0;
      m_cyc = 0;
      s = 0;
    end else begin
      for (int i = 0; i < SLOTS; i++) if (m_active[i]) e_busy = 1;
      if (fl) begin
        for (int i = 0; i < SLOTS; i++) m_active[i] = 0;
      end else if (!m_active[s]) begin
        e_ready = jv;
        if (jv) begin
          e_sel  = 2'd1;
          e_we   = 1;
          e_addr = AW'(s * N);
          m_active[s] = 1;
          m_start[s]  = m_cyc;
        end
      end else begin
        k = (m_cyc - m_start[s]) / SLOTS;
        if (k < N) begin
          e_sel  = 2'd2;
          e_we   = 1;
          e_addr = AW'(s * N + k);
        end else if (k < 2 * N) begin
          e_sel  = 2'd3;
          e_addr = AW'(s * N + int'(xa));
        end else begin
          e_rv = 1;
          m_active[s] = 0;
        end
      end
    end
    exp_q.push_back({e_ready, SLOT_W'(s), e_sel, e_we, e_addr, e_rv, e_busy});
    cyc_q.push_back(m_cyc);
    @(posedge i_clk);
    #1;
    if (rst_n) m_cyc++;
  endtask

  task automatic do_reset();
    repeat (2) step(0, 0, 0);
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_flush     = 1'b0;
    i_job_valid = 1'b0;
    i_xaddr     = '0;
    m_cyc       = 0;
    for (int i = 0; i < SLOTS; i++) begin
      m_active[i] = 0;
      m_start[i]  = 0;
    end
    @(posedge i_clk);
    #1;
    do_reset();

    // Feeder always ready: all slots fill, complete at 128.., refill at 144..
    for (int c = 0; c < 160; c++) step(1, 0, 1);

    // A single job at cycle 5
    do_reset();
    for (int c = 0; c < 150; c++) step(1, 0, c == 5);

    // Flush at cycle 70, then one job at cycle 72 into slot 8
    do_reset();
    for (int c = 0; c < 210; c++) step(1, c == 70, (c < 70) || (c == 72));

    // Reset pulsed mid-WRITE at cycle 40, then restart from slot 0
    do_reset();
    for (int c = 0; c < 40; c++) step(1, 0, 1);
    step(0, 0, 1);
    for (int c = 0; c < 100; c++) step(1, 0, 1);

    // Random offers with occasional flushes
    do_reset();
    for (int c = 0; c < 600; c++) step(1, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);

    @(negedge i_clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
